// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic tile sequencer.
//   state_t       : sequencer state encoding (IDLE, CLEAR, FEED, DRAIN, DONE)
//   drain_cycles  : wavefront drain length for a DIM x DIM tile (2*DIM-1)
//   lane_lsb      : LSB index of a lane inside a packed DATA_WIDTH*DIM bus
package systolic_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLEAR = 3'd1,
      FEED  = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } state_t;

   function automatic int drain_cycles(input int dim);
      return 2 * dim - 1;
   endfunction

   function automatic int lane_lsb(input int lane, input int width);
      return lane * width;
   endfunction

endpackage

// File: rtl/systolic_seq_ctrl_skew_line.sv
// One skew lane: delays a data word and its valid bit by DEPTH clocks and
// forces the output to zero whenever the delayed valid bit is low.
//   clk, rst_n : clock, asynchronous active-low reset (clears the pipeline)
//   din, vin   : incoming operand word and its valid bit
//   dout       : delayed word, zero when not valid
// DEPTH = 0 is a combinational pass-through (still masked by vin).
module skew_line #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic                  vin,
   output logic [DATA_WIDTH-1:0] dout
);

   if (DEPTH == 0) begin : g_pass
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;
      assign dout = vin ? din : '0;
   end else begin : g_delay
      logic [DEPTH-1:0][DATA_WIDTH-1:0] d_sr;
      logic [DEPTH-1:0]                 v_sr;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            d_sr <= '0;
            v_sr <= '0;
         end else begin
            d_sr[0] <= din;
            v_sr[0] <= vin;
            for (int i = 1; i < DEPTH; i++) begin
               d_sr[i] <= d_sr[i-1];
               v_sr[i] <= v_sr[i-1];
            end
         end
      end

      assign dout = v_sr[DEPTH-1] ? d_sr[DEPTH-1] : '0;
   end

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Sequencer for one DIM x DIM output-stationary systolic tile.
// Reads k_len operand vectors from the A/B buffers, skews lane j by j cycles,
// waits for the wavefront to drain and pulses done.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start, k_len        : tile request and reduction length
//   busy, done, acc_clr : status and accumulator clear pulse
//   a_rd_*, b_rd_*      : operand buffer read ports (1-cycle read latency)
//   arr_i_1, arr_i_2    : skewed operand buses to the array (A down, B right)
// Optional (macro SYSTOLIC_PERF_CNT_EN): perf_cycles (saturating busy-cycle
// count) and perf_tiles (wrapping completed-tile count).
//
// state | meaning
// IDLE  | waiting for start
// CLEAR | one-cycle accumulator clear
// FEED  | k_reg buffer reads, addresses 0..k_reg-1
// DRAIN | 2*DIM-1 cycles for the last product to reach PE[DIM-1][DIM-1]
// DONE  | one-cycle done pulse
module systolic_seq_ctrl
   import systolic_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int DIM        = 8,
   parameter int K_WIDTH    = 8,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic [K_WIDTH-1:0]        k_len,
   output logic                      busy,
   output logic                      done,
   output logic                      acc_clr,
   output logic                      a_rd_en,
   output logic [ADDR_WIDTH-1:0]     a_rd_addr,
   input  logic [DATA_WIDTH*DIM-1:0] a_rd_data,
   output logic                      b_rd_en,
   output logic [ADDR_WIDTH-1:0]     b_rd_addr,
   input  logic [DATA_WIDTH*DIM-1:0] b_rd_data,
   output logic [DATA_WIDTH*DIM-1:0] arr_i_1,
   output logic [DATA_WIDTH*DIM-1:0] arr_i_2
`ifdef SYSTOLIC_PERF_CNT_EN
   ,
   output logic [31:0]               perf_cycles,
   output logic [15:0]               perf_tiles
`endif
);

   localparam int DRN_W = (DIM > 1) ? $clog2(2 * DIM) : 1;
   localparam logic [DRN_W-1:0] DRN_LOAD = DRN_W'(drain_cycles(DIM) - 1);

   state_t                state, state_nxt;
   logic [K_WIDTH-1:0]    k_reg;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DRN_W-1:0]      drn_cnt;
   logic                  rd_valid;
   logic                  feed_last;
   logic                  drain_last;

   assign feed_last  = (state == FEED) &&
                       (addr == ADDR_WIDTH'(k_reg) - ADDR_WIDTH'(1));
   assign drain_last = (state == DRAIN) && (drn_cnt == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (start) state_nxt = (k_len == '0) ? DONE : CLEAR;
         CLEAR:   state_nxt = FEED;
         FEED:    if (feed_last) state_nxt = DRAIN;
         DRAIN:   if (drain_last) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy      = (state != IDLE);
      done      = (state == DONE);
      acc_clr   = (state == CLEAR);
      a_rd_en   = (state == FEED);
      b_rd_en   = (state == FEED);
      a_rd_addr = addr;
      b_rd_addr = addr;
   end

   // addr is held at zero outside FEED so the address buses idle low.
   // drn_cnt is a down-counter loaded during FEED; DRAIN ends at zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k_reg    <= '0;
         addr     <= '0;
         drn_cnt  <= '0;
         rd_valid <= 1'b0;
      end else begin
         if (state == IDLE && start) k_reg <= k_len;
         if (state == FEED && !feed_last) addr <= addr + ADDR_WIDTH'(1);
         else                             addr <= '0;
         if (state == FEED)       drn_cnt <= DRN_LOAD;
         else if (state == DRAIN) drn_cnt <= drn_cnt - DRN_W'(1);
         else                     drn_cnt <= '0;
         rd_valid <= (state == FEED);
      end
   end

   for (genvar j = 0; j < DIM; j++) begin : g_lane
      skew_line #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(j)) u_skew_a (
         .clk   (clk),
         .rst_n (rst_n),
         .din   (a_rd_data[lane_lsb(j, DATA_WIDTH) +: DATA_WIDTH]),
         .vin   (rd_valid),
         .dout  (arr_i_1[lane_lsb(j, DATA_WIDTH) +: DATA_WIDTH])
      );
      skew_line #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(j)) u_skew_b (
         .clk   (clk),
         .rst_n (rst_n),
         .din   (b_rd_data[lane_lsb(j, DATA_WIDTH) +: DATA_WIDTH]),
         .vin   (rd_valid),
         .dout  (arr_i_2[lane_lsb(j, DATA_WIDTH) +: DATA_WIDTH])
      );
   end

`ifdef SYSTOLIC_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_cycles <= '0;
         perf_tiles  <= '0;
      end else begin
         if (busy && perf_cycles != '1) perf_cycles <= perf_cycles + 32'd1;
         if (done) perf_tiles <= perf_tiles + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Self-checking bench for systolic_seq_ctrl (DIM=4).
module tb_systolic_seq_ctrl;

   localparam int DW  = 8;
   localparam int DIM = 4;
   localparam int KW  = 8;
   localparam int AW  = 8;
   localparam int BW  = DW * DIM;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [KW-1:0] k_len;
   logic          busy, done, acc_clr;
   logic          a_rd_en, b_rd_en;
   logic [AW-1:0] a_rd_addr, b_rd_addr;
   logic [BW-1:0] a_rd_data = '0;
   logic [BW-1:0] b_rd_data = '0;
   logic [BW-1:0] arr_i_1, arr_i_2;
`ifdef SYSTOLIC_PERF_CNT_EN
   logic [31:0]   perf_cycles;
   logic [15:0]   perf_tiles;
`endif

   systolic_seq_ctrl #(
      .DATA_WIDTH (DW),
      .DIM        (DIM),
      .K_WIDTH    (KW),
      .ADDR_WIDTH (AW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .k_len     (k_len),
      .busy      (busy),
      .done      (done),
      .acc_clr   (acc_clr),
      .a_rd_en   (a_rd_en),
      .a_rd_addr (a_rd_addr),
      .a_rd_data (a_rd_data),
      .b_rd_en   (b_rd_en),
      .b_rd_addr (b_rd_addr),
      .b_rd_data (b_rd_data),
      .arr_i_1   (arr_i_1),
      .arr_i_2   (arr_i_2)
`ifdef SYSTOLIC_PERF_CNT_EN
      ,
      .perf_cycles (perf_cycles),
      .perf_tiles  (perf_tiles)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic          busy;
      logic          done;
      logic          acc_clr;
      logic          a_en;
      logic          b_en;
      logic [AW-1:0] a_addr;
      logic [AW-1:0] b_addr;
      logic [BW-1:0] i1;
      logic [BW-1:0] i2;
   } obs_t;

   typedef struct {
      int k;
      int span;
      int reads;
      int clrs;
   } vec_t;

   int   checks = 0;
   int   errors = 0;
   int   busy_cnt = 0, rd_cnt = 0, done_cnt = 0, clr_cnt = 0;
   bit   ident_mode = 1'b0;
   obs_t exp_q[$];

   function automatic logic [DW-1:0] fa(int j, int a, bit id);
      if (id) return (a == j) ? DW'(1) : DW'(0);
      return DW'(16 * j + a);
   endfunction

   function automatic logic [DW-1:0] fb(int j, int a, bit id);
      if (id) return (a == j) ? DW'(1) : DW'(0);
      return DW'(128 + 8 * j + a);
   endfunction

   // Expected outputs t cycles after the start cycle (t=0 is the start cycle).
   function automatic obs_t model(int t, int k, bit id);
      obs_t o;
      int   last;
      int   a;
      o    = '0;
      last = (k > 0) ? k + 2 * DIM + 1 : 1;
      o.busy    = (t >= 1) && (t <= last);
      o.done    = (t == last);
      o.acc_clr = (k > 0) && (t == 1);
      if (k > 0 && t >= 2 && t <= k + 1) begin
         o.a_en   = 1'b1;
         o.b_en   = 1'b1;
         o.a_addr = AW'(t - 2);
         o.b_addr = AW'(t - 2);
      end
      for (int j = 0; j < DIM; j++) begin
         a = t - 3 - j;
         if (k > 0 && a >= 0 && a < k) begin
            o.i1[j*DW +: DW] = fa(j, a, id);
            o.i2[j*DW +: DW] = fb(j, a, id);
         end
      end
      return o;
   endfunction

   function automatic obs_t cur_obs();
      return {busy, done, acc_clr, a_rd_en, b_rd_en, a_rd_addr, b_rd_addr,
              arr_i_1, arr_i_2};
   endfunction

   task automatic check_obs(string name, obs_t got, obs_t exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic check_int(string name, int got, int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   // Operand buffers: synchronous read, data one cycle after rd_en.
   always @(posedge clk) begin
      if (a_rd_en)
         for (int j = 0; j < DIM; j++)
            a_rd_data[j*DW +: DW] <= fa(j, int'(a_rd_addr), ident_mode);
      if (b_rd_en)
         for (int j = 0; j < DIM; j++)
            b_rd_data[j*DW +: DW] <= fb(j, int'(b_rd_addr), ident_mode);
   end

   // Behavioural output-stationary array: A flows down, B flows right.
   logic [DW-1:0] pd  [DIM][DIM];
   logic [DW-1:0] pr  [DIM][DIM];
   logic [31:0]   acc [DIM][DIM];
   always @(posedge clk) begin
      logic [DW-1:0] dn, rt;
      for (int r = 0; r < DIM; r++)
         for (int c = 0; c < DIM; c++) begin
            dn = (r == 0) ? arr_i_1[c*DW +: DW] : pd[r-1][c];
            rt = (c == 0) ? arr_i_2[r*DW +: DW] : pr[r][c-1];
            pd[r][c]  <= dn;
            pr[r][c]  <= rt;
            acc[r][c] <= acc_clr ? 32'd0 : acc[r][c] + 32'(dn) * 32'(rt);
         end
   end

   // Scoreboard consumer: every cycle out of reset is compared.
   always @(negedge clk) begin
      obs_t e;
      if (rst_n) begin
         e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
         check_obs("cycle", cur_obs(), e);
         if (busy)    busy_cnt++;
         if (a_rd_en) rd_cnt++;
         if (done)    done_cnt++;
         if (acc_clr) clr_cnt++;
      end
   end

   task automatic push_run(int k, bit id);
      int last;
      last = (k > 0) ? k + 2 * DIM + 1 : 1;
      for (int t = 0; t <= last; t++) exp_q.push_back(model(t, k, id));
   endtask

   // Drives start for exactly one cycle; returns #1 into the next cycle.
   task automatic do_start(int k);
      start = 1'b1;
      k_len = KW'(k);
      push_run(k, ident_mode);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic run_vec(vec_t v, string name);
      int b0, r0, d0, c0;
      b0 = busy_cnt; r0 = rd_cnt; d0 = done_cnt; c0 = clr_cnt;
      do_start(v.k);
      repeat (v.k + 2 * DIM + 4) @(posedge clk);
      #1;
      check_int({name, "_busy_span"}, busy_cnt - b0, v.span);
      check_int({name, "_reads"},     rd_cnt - r0,   v.reads);
      check_int({name, "_dones"},     done_cnt - d0, 1);
      check_int({name, "_acc_clr"},   clr_cnt - c0,  v.clrs);
   endtask

   vec_t vecs[5];

   initial begin
      int d0;
      vecs[0] = '{k: 4,   span: 13,  reads: 4,   clrs: 1};
      vecs[1] = '{k: 0,   span: 1,   reads: 0,   clrs: 0};
      vecs[2] = '{k: 1,   span: 10,  reads: 1,   clrs: 1};
      vecs[3] = '{k: 7,   span: 16,  reads: 7,   clrs: 1};
      vecs[4] = '{k: 255, span: 264, reads: 255, clrs: 1};

      rst_n = 1'b0;
      start = 1'b0;
      k_len = '0;
      #3;
      check_obs("reset_state", cur_obs(), '0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Starts during FEED and in the done cycle are ignored; a start on the
      // cycle after done launches the next tile.
      d0 = done_cnt;
      do_start(3);                          // now in cycle 1 (CLEAR)
      @(posedge clk); #1;                   // cycle 2 (FEED)
      start = 1'b1; k_len = KW'(5);
      @(posedge clk); #1;
      start = 1'b0;                         // cycle 3
      repeat (9) @(posedge clk); #1;        // cycle 12 (DONE)
      start = 1'b1; k_len = KW'(7);
      @(posedge clk); #1;                   // cycle 13 (IDLE)
      do_start(2);
      repeat (2 + 2 * DIM + 4) @(posedge clk); #1;
      check_int("ignored_start_dones", done_cnt - d0, 2);

      // Asynchronous reset during DRAIN aborts the tile without done.
      d0 = done_cnt;
      do_start(4);                          // cycle 1
      repeat (6) @(posedge clk); #1;        // cycle 7 (DRAIN)
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      check_obs("reset_in_drain", cur_obs(), '0);
      repeat (3) @(posedge clk);
      check_int("reset_no_done", done_cnt - d0, 0);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      run_vec('{k: 2, span: 2 + 2 * DIM + 1, reads: 2, clrs: 1}, "after_reset");

      // End-to-end with identity operands through the array model.
      ident_mode = 1'b1;
      run_vec('{k: 4, span: 13, reads: 4, clrs: 1}, "identity");
      for (int r = 0; r < DIM; r++)
         for (int c = 0; c < DIM; c++)
            check_int($sformatf("pe_acc_%0d_%0d", r, c), int'(acc[r][c]),
                      (r == c) ? 1 : 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not reach the end");
      $fatal(1);
   end

endmodule

// File: doc/systolic_seq_ctrl.md
Name: systolic_seq_ctrl

Overview:
- Sequencer for one DIM x DIM output-stationary systolic tile. On start, it reads K operand vectors from the A (row) and B (column) operand buffers and applies the diagonal skew: lane j is delayed by j cycles.
- It drives the array's down (i_1) and right (i_2) input buses, and feeds zeros whenever no valid operand is present.
- It waits for the wavefront to drain, then signals done.
- It sits between the operand SRAMs/top-level control and the systolic / systolic_edge arrays.

Parameters:
- DATA_WIDTH, 8, operand width per lane
- DIM, 8, array dimension (lanes per bus)
- K_WIDTH, 8, width of the reduction-length field; max K = 2^K_WIDTH-1
- ADDR_WIDTH, 8, operand buffer address width (>= K_WIDTH)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to run one tile
- k_len  in  K_WIDTH  reduction length, sampled when start is accepted
- busy  out  1  high from the accepted start until done
- done  out  1  one-cycle pulse when all PE results are final
- acc_clr  out  1  one-cycle pulse clearing the array accumulators
- a_rd_en  out  1  A buffer read enable
- a_rd_addr  out  ADDR_WIDTH  A buffer address
- a_rd_data  in  DATA_WIDTH*DIM  A vector, valid 1 cycle after a_rd_en
- b_rd_en  out  1  B buffer read enable
- b_rd_addr  out  ADDR_WIDTH  B buffer address
- b_rd_data  in  DATA_WIDTH*DIM  B vector, valid 1 cycle after b_rd_en
- arr_i_1  out  DATA_WIDTH*DIM  to array i_1; lane j at [(j+1)*DATA_WIDTH-1 -: DATA_WIDTH]
- arr_i_2  out  DATA_WIDTH*DIM  to array i_2; same lane packing

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - All outputs 0, including busy, done, acc_clr, rd_en, addrs and arr buses.
  - All skew registers and valid bits are cleared.
- States: IDLE -> CLEAR -> FEED -> DRAIN -> DONE -> IDLE.
- IDLE:
  - start=1 latches k_len into k_reg and moves to CLEAR; busy rises the next cycle.
  - start=1 with k_len=0 goes directly to DONE: busy for 1 cycle, done pulses, no reads, no acc_clr.
- CLEAR: exactly 1 cycle with acc_clr=1; no reads.
- FEED:
  - k_reg cycles; a_rd_en = b_rd_en = 1.
  - Both addresses step 0,1,...,k_reg-1, one per cycle; A and B addresses are always identical.
- Skew path:
  - Each read's valid bit follows its data through the 1-cycle read latency.
  - Lane j of both A and B is then delayed by j registered cycles, so lane 0 has no added delay.
  - A lane whose valid bit is 0 outputs 0 on arr_i_1/arr_i_2. This keeps the always-accumulating array clean in every state.
- DRAIN:
  - Exactly 2*DIM-1 cycles after the last FEED cycle.
  - Justification: the last product reaches PE[DIM-1][DIM-1] at FEED-relative cycle k+2*DIM-2.
- DONE: 1 cycle, done=1, busy=1; then IDLE with busy=0.
- Total busy span = k + 2*DIM + 1 cycles (k>0).
- start while busy is ignored (no queuing).
- start and done in the same cycle: start is ignored. A new start is accepted only in IDLE, so a back-to-back tile is accepted one cycle after done.
- Counters:
  - Address counter is ADDR_WIDTH bits and never wraps, since k <= 2^K_WIDTH-1.
  - DRAIN counter is sized $clog2(2*DIM).
- Reset mid-operation:
  - Immediate abort to IDLE; no done pulse; the skew pipeline is flushed to zero.
  - Array accumulators are not cleared by the reset; the next run's CLEAR clears them.

Optional Feature:
- Macro SYSTOLIC_PERF_CNT_EN.
- Defined:
  - Adds output perf_cycles [31:0] and output perf_tiles [15:0], both reset to 0 by rst_n.
  - perf_cycles counts every busy=1 cycle and saturates at all-ones.
  - perf_tiles increments on each done pulse and wraps.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package systolic_pkg holds:
  - the state encoding, with localparams IDLE, CLEAR, FEED, DRAIN, DONE;
  - the DRAIN_CYCLES = 2*DIM-1 constant function;
  - the lane-slice index helper.
- Sub-module skew_line: one lane, parameterized DATA_WIDTH and DEPTH, with data and valid shift registers and async reset.
- It is instantiated 2*DIM times through generate, with DEPTH = j for lane j; DEPTH=0 is a wire pass-through.

Test Plan:
- Basic run, DIM=4, k_len=4, start at cycle 0:
  - acc_clr=1 at cycle 1.
  - rd_en high cycles 2-5 with addrs 0,1,2,3.
  - done high at cycle 13; busy high cycles 1-13.
- Skew check, A lane j data = 8'h10*j + addr:
  - arr_i_1 lane 2 shows 8'h20 first in cycle 5 (2 cycles after lane 0 shows 8'h00).
  - Every lane is 0 outside its valid window.
- End-to-end with systolic_edge, DIM=4, k=4, A=B=identity:
  - After done, the PE diagonal accumulators equal 1 and all other PEs equal 0.
- k_len=0:
  - busy for 1 cycle, done 1 cycle after start.
  - No rd_en, no acc_clr.
- start pulsed during FEED and again in the done cycle:
  - Both are ignored; exactly one done.
  - A start on the cycle after done is accepted.
- rst_n low during DRAIN:
  - All outputs are 0 asynchronously and there is no done.
  - After release, a new k_len=2 run completes in 2+2*DIM+1 cycles.
